// File: rtl/alu_seq_pkg.sv
// Shared types for the handshaked sequential ALU: opcode encoding,
// handshake FSM states and the multi-cycle opcode classifier.
package alu_seq_pkg;

    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_SLT   = 4'b0010,
        ALU_SLTU  = 4'b0011,
        ALU_AND   = 4'b0100,
        ALU_OR    = 4'b0101,
        ALU_XOR   = 4'b0110,
        ALU_SLL   = 4'b0111,
        ALU_SRL   = 4'b1000,
        ALU_SRA   = 4'b1001,
        ALU_MUL   = 4'b1010,
        ALU_MULHU = 4'b1011,
        ALU_DIVU  = 4'b1100,
        ALU_REMU  = 4'b1101,
        ALU_RSV0  = 4'b1110,
        ALU_RSV1  = 4'b1111
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_multicycle(input alu_op_t op);
        return (op == ALU_MUL) || (op == ALU_MULHU) ||
               (op == ALU_DIVU) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative unsigned multiplier / restoring divider. One step per clock,
// XLEN steps per operation, fixed latency regardless of operand values.
// Multiply: {hi,lo} ends as the full 2*XLEN product.
// Divide:   hi ends as the remainder, lo as the quotient. A zero divisor
// never borrows, so the quotient fills with ones and the remainder ends
// as the dividend, which is exactly the RISC-V divide-by-zero result.
module alu_seq_muldiv
    import alu_seq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_start,
    input  logic            i_is_div,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_done,
    output logic [XLEN-1:0] o_hi,
    output logic [XLEN-1:0] o_lo
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

    logic            r_busy;
    logic            r_is_div;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_b;
    logic            r_done;

    logic [XLEN:0]   w_mul_sum;
    logic [XLEN:0]   w_div_sh;
    logic [XLEN:0]   w_div_diff;
    logic            w_div_ok;

    // Per-step arithmetic for both the shift-add and restoring-subtract paths
    always_comb begin
        w_mul_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
        w_div_sh   = {r_hi, r_lo[XLEN-1]};
        w_div_diff = w_div_sh - {1'b0, r_b};
        w_div_ok   = ~w_div_diff[XLEN];
    end

    // Operand load on start, then one iteration per cycle with a done pulse after the last
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy   <= 1'b0;
            r_is_div <= 1'b0;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_busy   <= 1'b1;
                r_is_div <= i_is_div;
                r_cnt    <= CNT_LAST;
                r_hi     <= '0;
                r_lo     <= i_is_div ? i_a : i_b;
                r_b      <= i_is_div ? i_b : i_a;
            end else if (r_busy) begin
                if (r_is_div) begin
                    if (w_div_ok) begin
                        r_hi <= w_div_diff[XLEN-1:0];
                        r_lo <= {r_lo[XLEN-2:0], 1'b1};
                    end else begin
                        r_hi <= w_div_sh[XLEN-1:0];
                        r_lo <= {r_lo[XLEN-2:0], 1'b0};
                    end
                end else begin
                    {r_hi, r_lo} <= {w_mul_sum, r_lo[XLEN-1:1]};
                end
                if (r_cnt == '0) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end
    end

    assign o_done = r_done;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule

// File: rtl/alu_seq.sv
// Handshaked execute ALU: single-cycle ops are computed combinationally and
// registered on accept; MUL/MULHU/DIVU/REMU run on the iterative unit.
//
// state | meaning
// IDLE  | accepting requests; may also be holding a single-cycle result
// BUSY  | iterative multiply/divide running, waiting for its done pulse
// DONE  | multi-cycle result held until the consumer takes it
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      ALU_operation,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] ALU_result,
    output logic            Zero
);

    localparam int SHW = $clog2(XLEN);

    state_t          r_state;
    alu_op_t         r_op;
    logic [XLEN-1:0] r_result;
    logic            r_zero;
    logic            r_out_valid;

    alu_op_t         w_op;
    logic [SHW-1:0]  w_shamt;
    logic [XLEN-1:0] w_sc_result;
    logic [XLEN-1:0] w_md_result;
    logic            w_accept;
    logic            w_deliver;
    logic            w_md_start;
    logic            w_md_is_div;
    logic            w_md_done;
    logic [XLEN-1:0] w_md_hi;
    logic [XLEN-1:0] w_md_lo;

    assign w_op        = alu_op_t'(ALU_operation);
    assign w_shamt     = op2[SHW-1:0];
    assign in_ready    = (r_state == IDLE) && (!r_out_valid || out_ready);
    assign w_accept    = in_valid && in_ready;
    assign w_deliver   = r_out_valid && out_ready;
    assign w_md_start  = w_accept && is_multicycle(w_op);
    assign w_md_is_div = (w_op == ALU_DIVU) || (w_op == ALU_REMU);

    // Single-cycle datapath; SLT uses a true signed compare, not the sign of a difference
    always_comb begin
        w_sc_result = '0;
        case (w_op)
            ALU_ADD:  w_sc_result = op1 + op2;
            ALU_SUB:  w_sc_result = op1 - op2;
            ALU_SLT:  w_sc_result = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
            ALU_SLTU: w_sc_result = {{(XLEN-1){1'b0}}, (op1 < op2)};
            ALU_AND:  w_sc_result = op1 & op2;
            ALU_OR:   w_sc_result = op1 | op2;
            ALU_XOR:  w_sc_result = op1 ^ op2;
            ALU_SLL:  w_sc_result = op1 << w_shamt;
            ALU_SRL:  w_sc_result = op1 >> w_shamt;
            ALU_SRA:  w_sc_result = $unsigned($signed(op1) >>> w_shamt);
            default:  w_sc_result = '0;
        endcase
    end

    // Pick the half of the iterative result that the latched opcode asks for
    always_comb begin
        w_md_result = w_md_lo;
        case (r_op)
            ALU_MUL:   w_md_result = w_md_lo;
            ALU_MULHU: w_md_result = w_md_hi;
            ALU_DIVU:  w_md_result = w_md_lo;
            ALU_REMU:  w_md_result = w_md_hi;
            default:   w_md_result = w_md_lo;
        endcase
    end

    alu_seq_muldiv #(
        .XLEN (XLEN)
    ) u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_md_start),
        .i_is_div (w_md_is_div),
        .i_a      (op1),
        .i_b      (op2),
        .o_done   (w_md_done),
        .o_hi     (w_md_hi),
        .o_lo     (w_md_lo)
    );

    // Handshake FSM with registered result, Zero and out_valid
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_op        <= ALU_ADD;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (is_multicycle(w_op)) begin
                            r_op        <= w_op;
                            r_out_valid <= 1'b0;
                            r_state     <= BUSY;
                        end else begin
                            r_result    <= w_sc_result;
                            r_zero      <= (w_sc_result == '0);
                            r_out_valid <= 1'b1;
                        end
                    end else if (w_deliver) begin
                        r_out_valid <= 1'b0;
                    end
                end
                BUSY: begin
                    if (w_md_done) begin
                        r_result    <= w_md_result;
                        r_zero      <= (w_md_result == '0);
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (w_deliver) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign out_valid  = r_out_valid;
    assign ALU_result = r_result;
    assign Zero       = r_zero;

endmodule
